hex_frame_encoder: RTL and testbench

- Accepts a six-digit BCD frame over a valid/ready handshake and encodes it into active-low 7-segment patterns for HEX0..HEX5.
- Encodes serially, one digit per cycle, then commits all six displays in a single cycle so no partial frame is ever shown.
- Adds per-digit forced blanking, per-pair leading-zero blanking and per-digit blink.
- Sits between the date/counter logic and the board HEX pins; it is the encoding end of the segment interface that the bench decodes.

---
 rtl/hex_frame_encoder.sv | 181 ++++++++++++++++++
 tb/tb_hex_frame_encoder.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hex_frame_encoder.sv
// hex_frame_encoder
//   Accepts a six-digit BCD frame over valid/ready, encodes one digit per cycle into
//   active-low 7-segment patterns, then commits all six displays in one cycle.
//   Supports per-digit forced blank, per-pair leading-zero blank and per-digit blink.
//
// Ports:
//   ADC_CLK_10  in   system clock, rising edge
//   reset_n     in   asynchronous active-low reset
//   in_valid    in   frame offered
//   in_ready    out  block can accept a frame (IDLE)
//   in_bcd      in   digit i at [4i+3:4i], drives HEXi
//   in_blank    in   force digit i blank
//   in_lzb      in   leading-zero blank per pair (bit k covers HEX(2k+1):HEX(2k))
//   in_blink    in   blink enable per digit
//   done        out  one-cycle pulse after a frame is committed
//   HEX0..HEX5  out  active-low segments, bit7 = decimal point (always 1)
module hex_frame_encoder #(
    parameter int unsigned BLINK_HALF = 5000000
) (
    input  logic        ADC_CLK_10,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [23:0] in_bcd,
    input  logic [5:0]  in_blank,
    input  logic [2:0]  in_lzb,
    input  logic [5:0]  in_blink,
    output logic        done,
    output logic [7:0]  HEX0,
    output logic [7:0]  HEX1,
    output logic [7:0]  HEX2,
    output logic [7:0]  HEX3,
    output logic [7:0]  HEX4,
    output logic [7:0]  HEX5
);

    localparam int unsigned CW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ENCODE = 2'd1;
    localparam logic [1:0] COMMIT = 2'd2;

    logic [1:0]       state;
    logic [2:0]       idx;
    logic [23:0]      sh_bcd;
    logic [5:0]       sh_blank;
    logic [2:0]       sh_lzb;
    logic [5:0]       sh_blink;
    logic [5:0][7:0]  staging;
    logic [5:0][7:0]  hex_q;
    logic [5:0]       blink_mask;
    logic             done_q;
    logic [CW-1:0]    blink_cnt;
    logic             blink_phase;

    logic [3:0]       cur_val;
    logic             cur_blank;
    logic             cur_lzb;
    logic [7:0]       cur_seg;

    function automatic logic [7:0] seg_of(input logic [3:0] v);
        logic [7:0] s;
        case (v)
            4'd0:    s = 8'b1100_0000;
            4'd1:    s = 8'b1111_1001;
            4'd2:    s = 8'b1010_0100;
            4'd3:    s = 8'b1011_0000;
            4'd4:    s = 8'b1001_1001;
            4'd5:    s = 8'b1001_0010;
            4'd6:    s = 8'b1000_0010;
            4'd7:    s = 8'b1111_1000;
            4'd8:    s = 8'b1000_0000;
            4'd9:    s = 8'b1001_0000;
            default: s = 8'b1011_1111; // dash for non-BCD values
        endcase
        return s;
    endfunction

    assign in_ready = (state == IDLE);
    assign done     = done_q;

    // Select the shadow digit addressed by idx and its blanking controls.
    always_comb begin
        cur_val   = 4'h0;
        cur_blank = 1'b0;
        cur_lzb   = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (idx == 3'(i)) begin
                cur_val   = sh_bcd[4*i +: 4];
                cur_blank = sh_blank[i];
                // Only the upper (odd) digit of each pair is ever suppressed.
                cur_lzb   = ((i % 2) == 1) && sh_lzb[i/2];
            end
        end
    end

    always_comb begin
        if (cur_blank) begin
            cur_seg = 8'hFF;
        end else if (cur_lzb && (cur_val == 4'h0)) begin
            cur_seg = 8'hFF;
        end else begin
            cur_seg = seg_of(cur_val);
        end
    end

    always_ff @(posedge ADC_CLK_10 or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            idx        <= 3'd0;
            sh_bcd     <= '0;
            sh_blank   <= '0;
            sh_lzb     <= '0;
            sh_blink   <= '0;
            staging    <= '0;
            hex_q      <= {6{8'hFF}};
            blink_mask <= '0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sh_bcd   <= in_bcd;
                        sh_blank <= in_blank;
                        sh_lzb   <= in_lzb;
                        sh_blink <= in_blink;
                        idx      <= 3'd0;
                        state    <= ENCODE;
                    end
                end
                ENCODE: begin
                    for (int i = 0; i < 6; i++) begin
                        if (idx == 3'(i)) begin
                            staging[i] <= cur_seg;
                        end
                    end
                    if (idx == 3'd5) begin
                        idx   <= 3'd0;
                        state <= COMMIT;
                    end else begin
                        idx <= idx + 3'd1;
                    end
                end
                COMMIT: begin
                    hex_q      <= staging;
                    blink_mask <= sh_blink;
                    done_q     <= 1'b1;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Free-running blink timebase, independent of the frame FSM.
    always_ff @(posedge ADC_CLK_10 or negedge reset_n) begin
        if (!reset_n) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_cnt == CW'(BLINK_HALF - 1)) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt <= blink_cnt + CW'(1);
        end
    end

    // Output blanking gates only registered signals, so no combinational glitches.
    always_comb begin
        HEX0 = (blink_mask[0] && blink_phase) ? 8'hFF : hex_q[0];
        HEX1 = (blink_mask[1] && blink_phase) ? 8'hFF : hex_q[1];
        HEX2 = (blink_mask[2] && blink_phase) ? 8'hFF : hex_q[2];
        HEX3 = (blink_mask[3] && blink_phase) ? 8'hFF : hex_q[3];
        HEX4 = (blink_mask[4] && blink_phase) ? 8'hFF : hex_q[4];
        HEX5 = (blink_mask[5] && blink_phase) ? 8'hFF : hex_q[5];
    end

endmodule

// File: tb/tb_hex_frame_encoder.sv
// Bench for hex_frame_encoder: directed frames with hand-computed segment patterns.
// Expected frames are queued at acceptance; a monitor pops and compares on each done.
module tb_hex_frame_encoder;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] in_bcd;
    logic [5:0]  in_blank;
    logic [2:0]  in_lzb;
    logic [5:0]  in_blink;
    logic        done;
    logic [7:0]  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
    logic [47:0] hex_all;

    assign hex_all = {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};

    hex_frame_encoder #(.BLINK_HALF(2)) dut (
        .ADC_CLK_10 (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_bcd     (in_bcd),
        .in_blank   (in_blank),
        .in_lzb     (in_lzb),
        .in_blink   (in_blink),
        .done       (done),
        .HEX0       (HEX0),
        .HEX1       (HEX1),
        .HEX2       (HEX2),
        .HEX3       (HEX3),
        .HEX4       (HEX4),
        .HEX5       (HEX5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [47:0] hex;
        logic [5:0]  bmask;
    } exp_t;

    exp_t sb[$];
    int   compared   = 0;
    int   mismatched = 0;

    task automatic check(input string name, input logic [47:0] got, input logic [47:0] want);
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    // Monitor: every done pulse must match the oldest queued frame.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            compared++;
            if (sb.size() == 0) begin
                mismatched++;
                $display("FAIL unexpected_done: got done with empty queue, expected no done");
            end else begin
                exp_t e;
                logic ok;
                e  = sb.pop_front();
                ok = 1'b1;
                for (int i = 0; i < 6; i++) begin
                    if (e.bmask[i]) begin
                        if (hex_all[8*i +: 8] !== e.hex[8*i +: 8] && hex_all[8*i +: 8] !== 8'hFF)
                            ok = 1'b0;
                    end else if (hex_all[8*i +: 8] !== e.hex[8*i +: 8]) begin
                        ok = 1'b0;
                    end
                end
                if (!ok) begin
                    mismatched++;
                    $display("FAIL frame_compare: got %h, expected %h (blink mask %b)",
                             hex_all, e.hex, e.bmask);
                end
            end
        end
    end

    // Offer a frame, wait for acceptance, optionally queue its expectation.
    task automatic offer(input logic [23:0] bcd, input logic [5:0] blank, input logic [2:0] lzb,
                         input logic [5:0] blink, input logic [47:0] exp_hex,
                         input logic [5:0] bmask, input bit push);
        int n;
        @(negedge clk);
        in_bcd   = bcd;
        in_blank = blank;
        in_lzb   = lzb;
        in_blink = blink;
        in_valid = 1'b1;
        n = 0;
        while (in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            compared++;
            mismatched++;
            $display("FAIL accept_timeout: got in_ready=%b, expected 1", in_ready);
        end
        @(posedge clk);
        if (push) sb.push_back('{hex: exp_hex, bmask: bmask});
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(posedge clk);
            n++;
        end
        if (n >= 40) begin
            compared++;
            mismatched++;
            $display("FAIL drain_timeout: got %0d pending frames, expected 0", sb.size());
        end
        @(negedge clk);
    endtask

    logic [15:0] ready_vec;
    logic [15:0] done_vec;
    logic [7:0]  v0 [8];
    bit          ok_all;

    initial begin
        reset_n  = 1'b0;
        in_valid = 1'b0;
        in_bcd   = '0;
        in_blank = '0;
        in_lzb   = '0;
        in_blink = '0;

        // Reset state held for three cycles, then released.
        repeat (3) @(negedge clk);
        check("reset_hex", hex_all, {6{8'hFF}});
        check("reset_ready_done", {47'd0, in_ready, done}, 48'b10);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        check("post_reset_hex", hex_all, {6{8'hFF}});
        check("post_reset_ready_done", {47'd0, in_ready, done}, 48'b10);

        // Basic frame: HEX must hold until E7, done one cycle after E7.
        @(negedge clk);
        in_bcd = 24'h250107; in_lzb = 3'b011; in_blank = '0; in_blink = '0;
        in_valid = 1'b1;
        @(posedge clk);
        sb.push_back('{hex: 48'hA4_92_FF_F9_FF_F8, bmask: 6'b0});
        #1 in_valid = 1'b0;
        ok_all = 1'b1;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            if (hex_all !== {6{8'hFF}} || in_ready !== 1'b0 || done !== 1'b0) ok_all = 1'b0;
        end
        check("basic_hold_before_commit", {47'd0, ok_all}, 48'd1);
        drain();

        // Back-to-back: valid held; bcd changed while busy becomes frame B.
        @(negedge clk);
        in_bcd = 24'h123456; in_lzb = 3'b000; in_blank = '0; in_blink = '0;
        in_valid = 1'b1;
        @(posedge clk);
        sb.push_back('{hex: 48'hF9_A4_B0_99_92_82, bmask: 6'b0});
        #1 in_bcd = 24'h987650; in_lzb = 3'b111;
        ready_vec = '0;
        done_vec  = '0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            ready_vec[k] = in_ready;
            done_vec[k]  = done;
            if (k == 7) sb.push_back('{hex: 48'h90_80_F8_82_92_C0, bmask: 6'b0});
            if (k == 8) in_valid = 1'b0;
        end
        check("b2b_ready_pattern", {32'd0, ready_vec}, {32'd0, 16'h8080});
        check("b2b_done_pattern", {32'd0, done_vec}, {32'd0, 16'h8080});
        drain();

        // Priority: dash, forced blank over digit, even digit zero never suppressed.
        offer(24'h348A10, 6'b001000, 3'b001, 6'b0, 48'hB0_99_FF_BF_F9_C0, 6'b0, 1'b1);
        drain();
        offer(24'hF000C0, 6'b000000, 3'b111, 6'b0, 48'hBF_C0_FF_C0_BF_C0, 6'b0, 1'b1);
        drain();
        offer(24'hABCDEF, 6'b111111, 3'b111, 6'b0, {6{8'hFF}}, 6'b0, 1'b1);
        drain();
        offer(24'h090807, 6'b000000, 3'b111, 6'b0, 48'hFF_90_FF_80_FF_F8, 6'b0, 1'b1);
        drain();

        // Blink on HEX0 with a half-period of two cycles.
        offer(24'h000008, 6'b0, 3'b000, 6'b000001, 48'hC0_C0_C0_C0_C0_80, 6'b000001, 1'b1);
        drain();
        ok_all = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            v0[k] = HEX0;
            if (hex_all[47:8] !== {5{8'hC0}}) ok_all = 1'b0;
        end
        check("blink_others_steady", {47'd0, ok_all}, 48'd1);
        for (int k = 0; k < 6; k++) begin
            check($sformatf("blink_alt_%0d", k),
                  {46'd0, (v0[k] == 8'h80 || v0[k] == 8'hFF), (v0[k] != v0[k+2])}, 48'b11);
        end

        // Frame without blink clears the active mask.
        offer(24'h250107, 6'b0, 3'b011, 6'b0, 48'hA4_92_FF_F9_FF_F8, 6'b0, 1'b1);
        drain();
        ok_all = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (hex_all !== 48'hA4_92_FF_F9_FF_F8) ok_all = 1'b0;
        end
        check("blink_cleared_steady", {47'd0, ok_all}, 48'd1);

        // Reset at E3: frame dropped, displays blank at once, no done afterwards.
        offer(24'h111111, 6'b0, 3'b000, 6'b0, 48'd0, 6'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #1 reset_n = 1'b0;
        #1 check("midreset_hex", hex_all, {6{8'hFF}});
        check("midreset_ready_done", {47'd0, in_ready, done}, 48'b10);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("midreset_ready_after", {47'd0, in_ready}, 48'd1);
        ok_all = 1'b1;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (hex_all !== {6{8'hFF}}) ok_all = 1'b0;
        end
        check("midreset_frame_never_shown", {47'd0, ok_all}, 48'd1);

        // Recovery after the dropped frame.
        offer(24'h123456, 6'b0, 3'b000, 6'b0, 48'hF9_A4_B0_99_92_82, 6'b0, 1'b1);
        drain();

        check("queue_empty", {16'd0, 32'(sb.size())}, 48'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1);
    end

endmodule
